game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_pkg.sv | 22 ++
 rtl/game_ctrl_frame_timer.sv | 29 ++
 rtl/game_ctrl.sv | 130 +++++++++++++
 tb/tb_game_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game encodings: FSM states, ball speed bounds and winner codes.
// Also consumed by the display path.
package game_pkg;

    typedef enum logic [2:0] {
        ST_MENU      = 3'd0,
        ST_SETTINGS  = 3'd1,
        ST_SERVE     = 3'd2,
        ST_PLAY      = 3'd3,
        ST_PAUSE     = 3'd4,
        ST_GAME_OVER = 3'd5
    } game_state_t;

    localparam logic [3:0] SPEED_MIN = 4'd1;
    localparam logic [3:0] SPEED_MAX = 4'd8;
    localparam logic [3:0] SPEED_DEF = 4'd3;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/game_ctrl_frame_timer.sv
// Serve-delay frame counter: cleared while idle, counts ticks,
// done pulses combinationally on the tick that hits terminal count.
module frame_timer #(
    parameter int TERM = 59
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic done
);

    localparam logic [7:0] TERM_C = TERM[7:0];

    logic [7:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (tick) begin
            count <= count + 8'd1;
        end
    end

    assign done = tick && !clear && (count == TERM_C);

endmodule

// File: rtl/game_ctrl.sv
// Pong game sequencer: menu, speed settings, serve delay, scoring.
// Define GAME_CTRL_PAUSE_EN to enable start-button pause during play.
module game_ctrl
    import game_pkg::*;
#(
    parameter int WIN_SCORE    = 5,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_pulse,
    input  logic       setting_pulse,
    input  logic       up_pulse,
    input  logic       down_pulse,
    input  logic       refresh_tick,
    input  logic       point_p1,
    input  logic       point_p2,
    output logic [2:0] game_state,
    output logic       game_active,
    output logic       ball_reset,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [3:0] ball_speed,
    output logic       serve_dir,
    output logic [1:0] winner
);

    localparam logic [3:0] WIN_C = WIN_SCORE[3:0];

    game_state_t state;
    logic        serve_done;
    logic [3:0]  s1_inc;
    logic [3:0]  s2_inc;

    frame_timer #(
        .TERM(SERVE_FRAMES - 1)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .clear(state != ST_SERVE),
        .tick (refresh_tick),
        .done (serve_done)
    );

    assign s1_inc      = score1 + 4'd1;
    assign s2_inc      = score2 + 4'd1;
    assign game_state  = state;
    assign game_active = (state == ST_PLAY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_MENU;
            score1     <= 4'd0;
            score2     <= 4'd0;
            ball_speed <= SPEED_DEF;
            serve_dir  <= 1'b0;
            winner     <= WIN_NONE;
            ball_reset <= 1'b0;
        end else begin
            ball_reset <= 1'b0;
            case (state)
                ST_MENU: begin
                    if (start_pulse) begin
                        state      <= ST_SERVE;
                        score1     <= 4'd0;
                        score2     <= 4'd0;
                        winner     <= WIN_NONE;
                        serve_dir  <= 1'b0;
                        ball_reset <= 1'b1;
                    end else if (setting_pulse) begin
                        state <= ST_SETTINGS;
                    end
                end
                ST_SETTINGS: begin
                    if (setting_pulse || start_pulse)
                        state <= ST_MENU;
                    if (up_pulse && !down_pulse && ball_speed < SPEED_MAX)
                        ball_speed <= ball_speed + 4'd1;
                    else if (down_pulse && !up_pulse && ball_speed > SPEED_MIN)
                        ball_speed <= ball_speed - 4'd1;
                end
                ST_SERVE: begin
                    if (serve_done)
                        state <= ST_PLAY;
                end
                ST_PLAY: begin
                    // p1 wins a simultaneous point; the p2 pulse is dropped
                    if (point_p1) begin
                        score1 <= s1_inc;
                        if (s1_inc == WIN_C) begin
                            state  <= ST_GAME_OVER;
                            winner <= WIN_P1;
                        end else begin
                            state      <= ST_SERVE;
                            serve_dir  <= 1'b1;
                            ball_reset <= 1'b1;
                        end
                    end else if (point_p2) begin
                        score2 <= s2_inc;
                        if (s2_inc == WIN_C) begin
                            state  <= ST_GAME_OVER;
                            winner <= WIN_P2;
                        end else begin
                            state      <= ST_SERVE;
                            serve_dir  <= 1'b0;
                            ball_reset <= 1'b1;
                        end
                    end
`ifdef GAME_CTRL_PAUSE_EN
                    else if (start_pulse) begin
                        state <= ST_PAUSE;
                    end
`endif
                end
`ifdef GAME_CTRL_PAUSE_EN
                ST_PAUSE: begin
                    if (start_pulse)
                        state <= ST_PLAY;
                end
`endif
                ST_GAME_OVER: begin
                    if (start_pulse)
                        state <= ST_MENU;
                end
                default: state <= ST_MENU;
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with default WIN_SCORE=5, SERVE_FRAMES=60.
// Pause checks follow GAME_CTRL_PAUSE_EN.
module tb_game_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_pulse = 1'b0;
    logic       setting_pulse = 1'b0;
    logic       up_pulse = 1'b0;
    logic       down_pulse = 1'b0;
    logic       refresh_tick = 1'b0;
    logic       point_p1 = 1'b0;
    logic       point_p2 = 1'b0;
    logic [2:0] game_state;
    logic       game_active;
    logic       ball_reset;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [3:0] ball_speed;
    logic       serve_dir;
    logic [1:0] winner;

    int pass_cnt = 0;
    int total = 0;

    game_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start_pulse  (start_pulse),
        .setting_pulse(setting_pulse),
        .up_pulse     (up_pulse),
        .down_pulse   (down_pulse),
        .refresh_tick (refresh_tick),
        .point_p1     (point_p1),
        .point_p2     (point_p2),
        .game_state   (game_state),
        .game_active  (game_active),
        .ball_reset   (ball_reset),
        .score1       (score1),
        .score2       (score2),
        .ball_speed   (ball_speed),
        .serve_dir    (serve_dir),
        .winner       (winner)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_serve(input int n);
        for (int i = 0; i < n; i++) begin
            refresh_tick = 1'b1;
            step();
            refresh_tick = 1'b0;
        end
    endtask

    task automatic score_pt(input logic p1, input logic p2);
        point_p1 = p1;
        point_p2 = p2;
        step();
        point_p1 = 1'b0;
        point_p2 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        total++;
        if (game_state !== 3'd0) $display("FAIL reset_state got %0d exp 0", game_state);
        else pass_cnt++;
        total++;
        if ({score1, score2} !== 8'h00) $display("FAIL reset_scores got %h exp 00", {score1, score2});
        else pass_cnt++;
        total++;
        if (ball_speed !== 4'd3) $display("FAIL reset_speed got %0d exp 3", ball_speed);
        else pass_cnt++;
        total++;
        if ({serve_dir, winner, ball_reset, game_active} !== 5'b0)
            $display("FAIL reset_flags got %b exp 00000", {serve_dir, winner, ball_reset, game_active});
        else pass_cnt++;
    endtask

    task automatic test_settings();
        setting_pulse = 1'b1;
        step();
        setting_pulse = 1'b0;
        total++;
        if (game_state !== 3'd1) $display("FAIL enter_settings got %0d exp 1", game_state);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            up_pulse = 1'b1;
            step();
            up_pulse = 1'b0;
            step();
        end
        total++;
        if (ball_speed !== 4'd8) $display("FAIL speed_sat_max got %0d exp 8", ball_speed);
        else pass_cnt++;
        down_pulse = 1'b1;
        up_pulse = 1'b1;
        step();
        down_pulse = 1'b0;
        up_pulse = 1'b0;
        total++;
        if (ball_speed !== 4'd8) $display("FAIL speed_both got %0d exp 8", ball_speed);
        else pass_cnt++;
        down_pulse = 1'b1;
        for (int i = 0; i < 9; i++) step();
        down_pulse = 1'b0;
        total++;
        if (ball_speed !== 4'd1) $display("FAIL speed_sat_min got %0d exp 1", ball_speed);
        else pass_cnt++;
        up_pulse = 1'b1;
        for (int i = 0; i < 7; i++) step();
        up_pulse = 1'b0;
        setting_pulse = 1'b1;
        step();
        setting_pulse = 1'b0;
        total++;
        if ({game_state, ball_speed} !== {3'd0, 4'd8})
            $display("FAIL settings_exit got st=%0d spd=%0d exp st=0 spd=8", game_state, ball_speed);
        else pass_cnt++;
        up_pulse = 1'b1;
        step();
        up_pulse = 1'b0;
        total++;
        if (ball_speed !== 4'd8) $display("FAIL speed_hold_menu got %0d exp 8", ball_speed);
        else pass_cnt++;
    endtask

    task automatic test_serve();
        start_pulse = 1'b1;
        setting_pulse = 1'b1;
        step();
        start_pulse = 1'b0;
        setting_pulse = 1'b0;
        total++;
        if ({game_state, ball_reset} !== {3'd2, 1'b1})
            $display("FAIL serve_entry got st=%0d br=%b exp st=2 br=1", game_state, ball_reset);
        else pass_cnt++;
        step();
        total++;
        if (ball_reset !== 1'b0) $display("FAIL ball_reset_width got %b exp 0", ball_reset);
        else pass_cnt++;
        run_serve(59);
        total++;
        if ({game_state, game_active} !== {3'd2, 1'b0})
            $display("FAIL serve_59 got st=%0d act=%b exp st=2 act=0", game_state, game_active);
        else pass_cnt++;
        run_serve(1);
        total++;
        if ({game_state, game_active} !== {3'd3, 1'b1})
            $display("FAIL serve_60 got st=%0d act=%b exp st=3 act=1", game_state, game_active);
        else pass_cnt++;
    endtask

    task automatic test_points();
        score_pt(1'b0, 1'b1);
        total++;
        if ({game_state, score2, serve_dir, ball_reset} !== {3'd2, 4'd1, 1'b0, 1'b1})
            $display("FAIL p2_point got st=%0d s2=%0d dir=%b br=%b exp st=2 s2=1 dir=0 br=1",
                     game_state, score2, serve_dir, ball_reset);
        else pass_cnt++;
        score_pt(1'b1, 1'b0);
        total++;
        if ({score1, game_state} !== {4'd0, 3'd2})
            $display("FAIL point_in_serve got s1=%0d st=%0d exp s1=0 st=2", score1, game_state);
        else pass_cnt++;
        run_serve(60);
        score_pt(1'b1, 1'b1);
        total++;
        if ({score1, score2, serve_dir, game_state} !== {4'd1, 4'd1, 1'b1, 3'd2})
            $display("FAIL both_points got s1=%0d s2=%0d dir=%b st=%0d exp 1 1 1 2",
                     score1, score2, serve_dir, game_state);
        else pass_cnt++;
    endtask

    task automatic test_win();
        for (int i = 0; i < 3; i++) begin
            run_serve(60);
            score_pt(1'b1, 1'b0);
        end
        total++;
        if (score1 !== 4'd4) $display("FAIL score_four got %0d exp 4", score1);
        else pass_cnt++;
        run_serve(60);
        score_pt(1'b1, 1'b0);
        total++;
        if ({score1, winner, game_state, game_active, ball_reset} !== {4'd5, 2'b01, 3'd5, 1'b0, 1'b0})
            $display("FAIL win got s1=%0d w=%b st=%0d act=%b br=%b exp 5 01 5 0 0",
                     score1, winner, game_state, game_active, ball_reset);
        else pass_cnt++;
        score_pt(1'b0, 1'b1);
        score_pt(1'b1, 1'b0);
        setting_pulse = 1'b1;
        step();
        setting_pulse = 1'b0;
        total++;
        if ({score1, score2, winner, game_state} !== {4'd5, 4'd1, 2'b01, 3'd5})
            $display("FAIL over_hold got s1=%0d s2=%0d w=%b st=%0d exp 5 1 01 5",
                     score1, score2, winner, game_state);
        else pass_cnt++;
        start_pulse = 1'b1;
        step();
        start_pulse = 1'b0;
        total++;
        if ({game_state, score1} !== {3'd0, 4'd5})
            $display("FAIL over_to_menu got st=%0d s1=%0d exp st=0 s1=5", game_state, score1);
        else pass_cnt++;
        start_pulse = 1'b1;
        step();
        start_pulse = 1'b0;
        total++;
        if ({game_state, score1, score2, winner, serve_dir} !== {3'd2, 4'd0, 4'd0, 2'b00, 1'b0})
            $display("FAIL new_game got st=%0d s1=%0d s2=%0d w=%b dir=%b exp 2 0 0 00 0",
                     game_state, score1, score2, winner, serve_dir);
        else pass_cnt++;
    endtask

    task automatic test_pause();
        run_serve(60);
        start_pulse = 1'b1;
        step();
        start_pulse = 1'b0;
`ifdef GAME_CTRL_PAUSE_EN
        total++;
        if ({game_state, game_active} !== {3'd4, 1'b0})
            $display("FAIL pause_enter got st=%0d act=%b exp st=4 act=0", game_state, game_active);
        else pass_cnt++;
        score_pt(1'b1, 1'b0);
        total++;
        if ({score1, game_state} !== {4'd0, 3'd4})
            $display("FAIL pause_point got s1=%0d st=%0d exp 0 4", score1, game_state);
        else pass_cnt++;
        start_pulse = 1'b1;
        step();
        start_pulse = 1'b0;
        total++;
        if ({game_state, game_active} !== {3'd3, 1'b1})
            $display("FAIL pause_exit got st=%0d act=%b exp st=3 act=1", game_state, game_active);
        else pass_cnt++;
`else
        total++;
        if ({game_state, game_active} !== {3'd3, 1'b1})
            $display("FAIL start_in_play got st=%0d act=%b exp st=3 act=1", game_state, game_active);
        else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid();
        score_pt(1'b1, 1'b0);
        run_serve(60);
        score_pt(1'b1, 1'b0);
        run_serve(60);
        score_pt(1'b1, 1'b0);
        run_serve(60);
        score_pt(1'b0, 1'b1);
        run_serve(60);
        score_pt(1'b0, 1'b1);
        run_serve(20);
        total++;
        if ({game_state, score1, score2} !== {3'd2, 4'd3, 4'd2})
            $display("FAIL pre_reset got st=%0d s1=%0d s2=%0d exp 2 3 2", game_state, score1, score2);
        else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({game_state, score1, score2, ball_speed, winner, game_active} !==
            {3'd0, 4'd0, 4'd0, 4'd3, 2'b00, 1'b0})
            $display("FAIL async_reset got st=%0d s1=%0d s2=%0d spd=%0d w=%b act=%b exp 0 0 0 3 00 0",
                     game_state, score1, score2, ball_speed, winner, game_active);
        else pass_cnt++;
        step();
        reset = 1'b0;
        start_pulse = 1'b1;
        step();
        start_pulse = 1'b0;
        run_serve(59);
        total++;
        if (game_state !== 3'd2) $display("FAIL timer_cleared got st=%0d exp 2", game_state);
        else pass_cnt++;
        run_serve(1);
        total++;
        if (game_state !== 3'd3) $display("FAIL timer_after_reset got st=%0d exp 3", game_state);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_settings();
        test_serve();
        test_points();
        test_win();
        test_pause();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
